// File: rtl/raiz_iter_core_if.sv
// Operand/result bundle between the Raiz control path and the square-root engine.
// The core takes the slave side; the calculator control (or a bench) takes the master side.
interface raiz_iter_core_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   INIT;
    logic [2*WIDTH-1:0]     RADICANDO;
    logic [WIDTH-1:0]       Resultado;
    logic [WIDTH:0]         RESIDUO;
    logic                   LD;
    logic                   LD_TMP;
    logic                   BUSY;
    logic                   DONE;

    modport master (
        output INIT,
        output RADICANDO,
        input  Resultado,
        input  RESIDUO,
        input  LD,
        input  LD_TMP,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  INIT,
        input  RADICANDO,
        output Resultado,
        output RESIDUO,
        output LD,
        output LD_TMP,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/raiz_iter_core.sv
// Iterative floor(sqrt) engine: digit-by-digit, two radicand bits consumed per clock.
// Drives the clear/load strobes and data of the downstream root temporary register.
module raiz_iter_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    raiz_iter_core_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ITER,
        S_FIN
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [2*WIDTH-1:0]   r_shift;
    logic [WIDTH+2:0]     r_rem;
    logic [WIDTH-1:0]     r_root;
    logic [WIDTH:0]       r_residuo;
    logic [CW-1:0]        r_cnt;
    logic                 r_ld;
    logic                 r_ld_tmp;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH+2:0]     w_rem_s;
    logic [WIDTH+2:0]     w_trial;
    logic [WIDTH+2:0]     w_rem_next;
    logic [WIDTH-1:0]     w_root_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.INIT) w_next = S_CLEAR;
            S_CLEAR: w_next = S_ITER;
            S_ITER:  if (r_cnt == '0) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Remainder path is WIDTH+3 wide so the shifted remainder and trial divisor never wrap.
    always_comb begin
        w_rem_s     = (r_rem << 2) | {{(WIDTH+1){1'b0}}, r_shift[2*WIDTH-1 -: 2]};
        w_trial     = {1'b0, r_root, 2'b01};
        w_rem_next  = w_rem_s;
        w_root_next = r_root << 1;
        if (w_rem_s >= w_trial) begin
            w_rem_next  = w_rem_s - w_trial;
            w_root_next = (r_root << 1) | WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift   <= '0;
            r_rem     <= '0;
            r_root    <= '0;
            r_residuo <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.INIT) begin
                        r_shift <= bus.RADICANDO;
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_CLEAR: begin
                    r_root <= '0;
                    r_rem  <= '0;
                end
                S_ITER: begin
                    r_rem   <= w_rem_next;
                    r_root  <= w_root_next;
                    r_shift <= r_shift << 2;
                    r_cnt   <= r_cnt - 1'b1;
                    // Load on the last step so RESIDUO is already valid while DONE is high.
                    if (r_cnt == '0) r_residuo <= w_rem_next[WIDTH:0];
                end
                S_FIN: begin
                    r_residuo <= r_rem[WIDTH:0];
                end
                default: ;
            endcase
        end
    end

    // Strobes are registered from the next state so each lines up with its state's cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ld     <= 1'b0;
            r_ld_tmp <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ld     <= (w_next == S_CLEAR);
            r_ld_tmp <= (w_next == S_FIN);
            r_done   <= (w_next == S_FIN);
            r_busy   <= (w_next != S_IDLE);
        end
    end

    assign bus.Resultado = r_root;
    assign bus.RESIDUO   = r_residuo;
    assign bus.LD        = r_ld;
    assign bus.LD_TMP    = r_ld_tmp;
    assign bus.BUSY      = r_busy;
    assign bus.DONE      = r_done;
endmodule

// File: tb/tb_raiz_iter_core.sv
// Bench for raiz_iter_core: a timeline/arithmetic model checked every cycle,
// plus directed jobs with literal expected roots, residues and latencies.
module tb_raiz_iter_core;
    localparam int unsigned W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    raiz_iter_core_if #(.WIDTH(W)) bus ();

    raiz_iter_core #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint isqrt(input longint n);
        longint r;
        r = longint'($rtoi($sqrt(real'(n))));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Model: a job accepted at edge k occupies the W+2 cycles after it; after i
    // root bits the partial root is isqrt of the top 2*i radicand bits.
    longint e        = 0;
    longint m_k      = 0;
    longint m_n      = 0;
    longint m_root   = 0;
    longint m_res    = 0;
    bit     m_active = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            m_root   = 0;
            m_res    = 0;
        end else begin
            e++;
            if (m_active && e == m_k + W + 2) begin
                m_active = 0;
            end else if (!m_active && bus.INIT) begin
                m_active = 1;
                m_k      = e;
                m_n      = longint'(bus.RADICANDO);
            end
            if (m_active && e == m_k + W + 1) begin
                m_root = isqrt(m_n);
                m_res  = m_n - m_root * m_root;
            end
        end
    end

    always @(negedge clk) begin : compare
        longint p;
        longint er;
        p  = e - m_k;
        er = m_root;
        if (m_active && p >= 1) er = isqrt(m_n >> (2 * (W - (p - 1))));
        chk("Resultado", 64'(bus.Resultado), 64'(er));
        chk("RESIDUO",   64'(bus.RESIDUO),   64'(m_res));
        chk("LD",        64'(bus.LD),        64'(m_active && p == 0));
        chk("LD_TMP",    64'(bus.LD_TMP),    64'(m_active && p == W + 1));
        chk("DONE",      64'(bus.DONE),      64'(m_active && p == W + 1));
        chk("BUSY",      64'(bus.BUSY),      64'(m_active));
    end

    longint got_root, got_res;
    int     lat, ld_at, busy_n;

    // Call at a negedge with the core idle; returns at the negedge after FIN.
    task automatic run_job(input longint n);
        bus.INIT      = 1'b1;
        bus.RADICANDO = (2*W)'(n);
        lat = 0; ld_at = 0; busy_n = 0; got_root = -1; got_res = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.INIT = 1'b0;
            if (bus.LD) ld_at = i;
            if (bus.BUSY) busy_n++;
            if (bus.DONE) begin
                lat      = i;
                got_root = longint'(bus.Resultado);
                got_res  = longint'(bus.RESIDUO);
                break;
            end
        end
        if (lat == 0) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        int dn;
        int bad;
        longint n;

        bus.INIT      = 1'b0;
        bus.RADICANDO = '0;

        chk("model_isqrt_144",  64'(isqrt(144)),          64'd12);
        chk("model_isqrt_200",  64'(isqrt(200)),          64'd14);
        chk("model_isqrt_1000", 64'(isqrt(1000)),         64'd31);
        chk("model_isqrt_max",  64'(isqrt(64'hFFFFFFFF)), 64'hFFFF);

        repeat (3) @(negedge clk);
        chk("reset_Resultado", 64'(bus.Resultado), 0);
        chk("reset_RESIDUO",   64'(bus.RESIDUO),   0);
        chk("reset_BUSY",      64'(bus.BUSY),      0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_job(144);
        chk("j144_root",  64'(got_root), 64'd12);
        chk("j144_res",   64'(got_res),  64'd0);
        chk("j144_ld_at", 64'(ld_at),    64'd1);
        chk("j144_lat",   64'(lat),      64'd18);
        chk("j144_busy",  64'(busy_n),   64'd18);

        run_job(200);
        chk("j200_root", 64'(got_root), 64'd14);
        chk("j200_res",  64'(got_res),  64'd4);
        run_job(1);
        chk("j1_root", 64'(got_root), 64'd1);
        chk("j1_res",  64'(got_res),  64'd0);
        run_job(0);
        chk("j0_root", 64'(got_root), 64'd0);
        chk("j0_res",  64'(got_res),  64'd0);
        run_job(64'hFFFFFFFF);
        chk("jmax_root", 64'(got_root), 64'hFFFF);
        chk("jmax_res",  64'(got_res),  64'h1FFFE);

        // INIT pulse with a new operand mid-job must be ignored.
        bus.INIT = 1'b1; bus.RADICANDO = 32'd144;
        dn = 0; got_root = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) bus.INIT = 1'b0;
            if (i == 4) begin bus.INIT = 1'b1; bus.RADICANDO = 32'd9; end
            if (i == 5) bus.INIT = 1'b0;
            if (bus.DONE) begin dn++; got_root = longint'(bus.Resultado); end
        end
        chk("ign_root",  64'(got_root), 64'd12);
        chk("ign_dones", 64'(dn),       64'd1);

        // Reset mid-job aborts without DONE/LD_TMP.
        bus.INIT = 1'b1; bus.RADICANDO = 32'd1000;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) bus.INIT = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("abort_Resultado", 64'(bus.Resultado), 0);
        chk("abort_RESIDUO",   64'(bus.RESIDUO),   0);
        chk("abort_LD",        64'(bus.LD),        0);
        chk("abort_LD_TMP",    64'(bus.LD_TMP),    0);
        chk("abort_BUSY",      64'(bus.BUSY),      0);
        chk("abort_DONE",      64'(bus.DONE),      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.DONE || bus.LD_TMP) bad++;
        end
        chk("abort_no_done", 64'(bad), 0);
        run_job(1000);
        chk("j1000_root", 64'(got_root), 64'd31);
        chk("j1000_res",  64'(got_res),  64'd39);

        // INIT held high: back-to-back jobs, next accepted one cycle after FIN.
        bus.INIT = 1'b1; bus.RADICANDO = 32'd49;
        dn = 0;
        for (int i = 1; i <= 38; i++) begin
            @(negedge clk);
            if (bus.DONE) dn++;
        end
        bus.INIT = 1'b0;
        repeat (3) @(negedge clk);
        chk("cont_dones", 64'(dn), 64'd2);

        for (int j = 0; j < 1000; j++) begin
            n = longint'($urandom);
            run_job(n);
            chk("rnd_lo",  64'(got_root * got_root <= n), 1);
            chk("rnd_hi",  64'((got_root + 1) * (got_root + 1) > n), 1);
            chk("rnd_res", 64'(got_res), 64'(n - got_root * got_root));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/raiz_iter_core.md
Name: raiz_iter_core

Overview:
- Iterative integer square-root engine for the calculator's Raiz path.
- Computes floor(sqrt(RADICANDO)) with the digit-by-digit (two bits per step) method, one root bit per clock.
- Sits directly upstream of the root temporary register and drives that register's clear strobe (LD), load strobe (LD_TMP) and data input (Resultado).
- Also reports the remainder and completion to the calculator's top-level control.

Parameters:
- WIDTH, 16, root width in bits. Radicand width is 2*WIDTH. Remainder width is WIDTH+1.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- INIT  input  1  start request, sampled only in IDLE.
- RADICANDO  input  2*WIDTH  unsigned operand, captured on the accepted INIT edge.
- Resultado  output  WIDTH  partial or final root (registered).
- RESIDUO  output  WIDTH+1  RADICANDO - Resultado^2, valid when DONE=1 (registered).
- LD  output  1  one-cycle clear strobe to the downstream temp register.
- LD_TMP  output  1  one-cycle load strobe to the downstream temp register.
- BUSY  output  1  high from the accepted INIT until the end of FIN.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous, while RST_N=0:
  - state=IDLE.
  - Resultado, RESIDUO, LD, LD_TMP, BUSY, DONE all 0.
  - Internal operand shift register, remainder register and iteration counter all 0.
  - Asserting reset mid-operation aborts immediately. No LD_TMP or DONE is issued for the aborted job.
- States: IDLE, CLEAR, ITER, FIN.
- IDLE:
  - If INIT=1 at a clock edge: capture RADICANDO into the shift register, set counter=WIDTH-1, go to CLEAR.
  - Otherwise hold. Resultado and RESIDUO keep the last job's values.
- CLEAR (1 cycle):
  - LD=1, BUSY=1.
  - Resultado<=0, remainder<=0.
  - Next state: ITER.
- ITER (exactly WIDTH cycles, BUSY=1). Each cycle:
  - rem_s = (rem<<2) | top two bits of the shift register.
  - trial = (Resultado<<2) | 1.
  - If rem_s >= trial: rem <= rem_s - trial, Resultado <= (Resultado<<1)|1.
  - Else: rem <= rem_s, Resultado <= Resultado<<1.
  - Shift register shifts left by 2.
  - Counter decrements. On the cycle where counter=0, go to FIN.
- FIN (1 cycle):
  - LD_TMP=1, DONE=1, BUSY=1.
  - RESIDUO <= rem, holding the final remainder.
  - Resultado is stable and final during this cycle.
  - Next state: IDLE.
- Latency:
  - INIT accepted at edge k.
  - LD high during cycle k+1.
  - DONE and LD_TMP high during cycle k+2+WIDTH (k+18 at default).
  - A new INIT is accepted at the edge that ends FIN + 1, i.e. in IDLE only.
- Width rules:
  - Internal remainder datapath is WIDTH+3 bits, so rem_s and trial never overflow.
  - All comparisons and subtractions are unsigned.
  - Final remainder always fits WIDTH+1 bits (max 2*root).
- Boundary conditions:
  - INIT while BUSY=1 is ignored, with no re-capture. RADICANDO changes after capture have no effect.
  - INIT held high continuously: a new job starts on each return to IDLE.
  - RADICANDO=0 gives root 0, residue 0.
  - RADICANDO=all-ones gives root=all-ones, residue=2*(2^WIDTH-1).
- Output discipline:
  - LD, LD_TMP and DONE are never high in the same cycle except LD_TMP with DONE.
  - Each strobe is exactly one cycle wide.

Test Plan:
- Reset then INIT with RADICANDO=144:
  - LD pulse in cycle k+1.
  - DONE and LD_TMP in cycle k+18.
  - Resultado=12, RESIDUO=0.
  - BUSY high for 18 cycles.
- RADICANDO=200 -> Resultado=14, RESIDUO=4. RADICANDO=1 -> Resultado=1, RESIDUO=0. RADICANDO=0 -> Resultado=0, RESIDUO=0.
- RADICANDO=0xFFFFFFFF -> Resultado=0xFFFF, RESIDUO=0x1FFFE, with no overflow.
- Job on 144, then INIT pulse with RADICANDO=9 at cycle k+5:
  - The pulse is ignored.
  - Result is 12, and exactly one DONE occurs.
- RST_N dropped at cycle k+10 of a job on 1000, then released:
  - All outputs 0 immediately, with no DONE or LD_TMP.
  - New INIT with 1000 -> Resultado=31, RESIDUO=39.
- Random sweep of 1000 radicands against a reference model:
  - Resultado^2 <= N < (Resultado+1)^2.
  - RESIDUO = N - Resultado^2.
